// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller port bundle: ID/EX decode fields in, pipeline stall/flush controls out.
// master = datapath side, slave = hazard_ctrl_unit.
interface hazard_ctrl_unit_if;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_muldiv;
    logic       stall;
    logic       id_bubble;
    logic       ex_hold;
    logic       flush;
    logic       muldiv_busy;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd,
               ex_mem_read, ex_branch_taken, ex_muldiv,
        input  stall, id_bubble, ex_hold, flush, muldiv_busy
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd,
               ex_mem_read, ex_branch_taken, ex_muldiv,
        output stall, id_bubble, ex_hold, flush, muldiv_busy
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes and, when MULDIV_STALL_EN
// is defined, a fixed-latency EX hold for M-extension ops (MULDIV_LATENCY total EX cycles).
module hazard_ctrl_unit #(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_unit_if.slave  hz
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    if ((MULDIV_LATENCY < 2) || (MULDIV_LATENCY > 32)) begin : g_bad_latency
        $error("hazard_ctrl_unit: MULDIV_LATENCY must be in 2..32");
    end

    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_AMO);
    endfunction

    logic load_use_s;
    logic redirect_s;
    logic stall_s;
    logic id_bubble_s;
    logic ex_hold_s;
    logic flush_s;
    logic muldiv_busy_s;

    // Hazard detection between the ID and EX slots
    always_comb begin
        load_use_s = 1'b0;
        redirect_s = 1'b0;
        if (hz.ex_mem_read && (hz.ex_rd != 5'd0)) begin
            load_use_s = (uses_rs1(hz.id_opcode) && (hz.ex_rd == hz.id_rs1)) ||
                         (uses_rs2(hz.id_opcode) && (hz.ex_rd == hz.id_rs2));
        end else begin
            load_use_s = 1'b0;
        end
        redirect_s = ((hz.ex_opcode == OP_BRANCH) && hz.ex_branch_taken) ||
                     (hz.ex_opcode == OP_JAL) || (hz.ex_opcode == OP_JALR);
    end

`ifdef MULDIV_STALL_EN
    localparam int              CNT_W    = $clog2(MULDIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Loaded value leaves MULDIV_LATENCY-2 further stall cycles after the entry cycle
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LATENCY - 2);

    typedef enum logic [0:0] {
        ST_RUN         = 1'b0,
        ST_MULDIV_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;

    // State and wait-counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state and pipeline-control decode; redirect outranks muldiv outranks load-use
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        stall_s     = 1'b0;
        id_bubble_s = 1'b0;
        ex_hold_s   = 1'b0;
        flush_s     = 1'b0;
        if (reset) begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_s) begin
                        flush_s = 1'b1;
                    end else if (hz.ex_muldiv) begin
                        stall_s   = 1'b1;
                        ex_hold_s = 1'b1;
                        // A two-cycle op needs only this entry stall, so no wait state
                        if (MULDIV_LATENCY > 2) begin
                            state_nx_s = ST_MULDIV_WAIT;
                            cnt_nx_s   = CNT_INIT;
                        end else begin
                            state_nx_s = ST_RUN;
                        end
                    end else if (load_use_s) begin
                        stall_s     = 1'b1;
                        id_bubble_s = 1'b1;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_MULDIV_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        stall_s   = 1'b1;
                        ex_hold_s = 1'b1;
                        cnt_nx_s  = cnt_r - CNT_ONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                default: begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end
    end

    assign muldiv_busy_s = (state_r == ST_MULDIV_WAIT) && !reset;

`else
    logic unused_s;
    // Single-cycle multiplier build: no EX hold, only redirect and load-use
    always_comb begin
        stall_s     = 1'b0;
        id_bubble_s = 1'b0;
        ex_hold_s   = 1'b0;
        flush_s     = 1'b0;
        if (reset) begin
            flush_s = 1'b0;
        end else if (redirect_s) begin
            flush_s = 1'b1;
        end else if (load_use_s) begin
            stall_s     = 1'b1;
            id_bubble_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign muldiv_busy_s = 1'b0;
    assign unused_s      = ^{clk, hz.ex_muldiv, 1'(MULDIV_LATENCY)};
`endif

    assign hz.stall       = stall_s;
    assign hz.id_bubble   = id_bubble_s;
    assign hz.ex_hold     = ex_hold_s;
    assign hz.flush       = flush_s;
    assign hz.muldiv_busy = muldiv_busy_s;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: two instances (latency 4 and 8) driven with
// identical directed and random stimulus, compared against a cycle-age reference model.
module tb_hazard_ctrl_unit;

`ifdef MULDIV_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011, AMO = 7'b0101111, LD = 7'b0000011;
    localparam logic [6:0] IMM = 7'b0010011, SYS = 7'b1110011;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   age4;
    int   age8;

    hazard_ctrl_unit_if if4 ();
    hazard_ctrl_unit_if if8 ();

    hazard_ctrl_unit #(.MULDIV_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .hz(if4));
    hazard_ctrl_unit #(.MULDIV_LATENCY(8)) dut8 (.clk(clk), .reset(reset), .hz(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 'age' counts cycles an M op has already spent in EX (0 = none in flight).
    // Result bits: [4] stall [3] id_bubble [2] ex_hold [1] flush [0] muldiv_busy
    function automatic void ref_model(input int lat, input logic rst,
                                      input logic [6:0] idop, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [6:0] exop,
                                      input logic [4:0] exrd, input logic mr,
                                      input logic bt, input logic md, input int age,
                                      output logic [4:0] exp, output int age_nx);
        logic r1u, r2u, lu, rd;
        r1u = !(idop inside {LUI, AUIPC, JAL});
        r2u = idop inside {BR, ST, RT, AMO};
        lu  = mr && (exrd != 5'd0) && ((r1u && exrd == rs1) || (r2u && exrd == rs2));
        rd  = (exop == BR && bt) || exop == JAL || exop == JALR;
        exp    = 5'b00000;
        age_nx = age;
        if (rst) begin
            age_nx = 0;
        end else if (age == 0) begin
            if (rd) begin
                exp[1] = 1'b1;
            end else if (md && MD_EN) begin
                exp[4] = 1'b1;
                exp[2] = 1'b1;
                age_nx = (lat > 2) ? 1 : 0;
            end else if (lu) begin
                exp[4] = 1'b1;
                exp[3] = 1'b1;
            end
        end else begin
            exp[0] = 1'b1;
            if (age + 1 <= lat - 1) begin
                exp[4] = 1'b1;
                exp[2] = 1'b1;
            end
            age_nx = (age + 1 == lat) ? 0 : age + 1;
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [6:0] idop, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [6:0] exop, input logic [4:0] exrd,
                        input logic mr, input logic bt, input logic md);
        logic [4:0] e4, e8;
        int n4, n8;
        @(negedge clk);
        reset = rst;
        if4.id_opcode = idop; if4.id_rs1 = rs1; if4.id_rs2 = rs2; if4.ex_opcode = exop;
        if4.ex_rd = exrd; if4.ex_mem_read = mr; if4.ex_branch_taken = bt; if4.ex_muldiv = md;
        if8.id_opcode = idop; if8.id_rs1 = rs1; if8.id_rs2 = rs2; if8.ex_opcode = exop;
        if8.ex_rd = exrd; if8.ex_mem_read = mr; if8.ex_branch_taken = bt; if8.ex_muldiv = md;
        #1;
        ref_model(4, rst, idop, rs1, rs2, exop, exrd, mr, bt, md, age4, e4, n4);
        ref_model(8, rst, idop, rs1, rs2, exop, exrd, mr, bt, md, age8, e8, n8);
        check("l4_stall",     if4.stall,       e4[4]);
        check("l4_id_bubble", if4.id_bubble,   e4[3]);
        check("l4_ex_hold",   if4.ex_hold,     e4[2]);
        check("l4_flush",     if4.flush,       e4[1]);
        check("l4_busy",      if4.muldiv_busy, e4[0]);
        check("l8_stall",     if8.stall,       e8[4]);
        check("l8_id_bubble", if8.id_bubble,   e8[3]);
        check("l8_ex_hold",   if8.ex_hold,     e8[2]);
        check("l8_flush",     if8.flush,       e8[1]);
        check("l8_busy",      if8.muldiv_busy, e8[0]);
        age4 = n4;
        age8 = n8;
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] tbl [12];
        tbl = '{RT, LD, ST, BR, JAL, JALR, IMM, LUI, AUIPC, AMO, SYS, 7'b0000000};
        if ($urandom_range(0, 7) == 0) return 7'($urandom);
        return tbl[$urandom_range(0, 11)];
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        age4   = 0;
        age8   = 0;
        reset  = 1'b1;

        // reset state
        step(1'b1, RT, 5'd1, 5'd2, RT, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, RT, 5'd5, 5'd2, LD, 5'd5, 1'b1, 1'b0, 1'b1);
        step(1'b0, IMM, 5'd1, 5'd2, IMM, 5'd3, 1'b0, 1'b0, 1'b0);
        // load-use on rs1, then the dependent op has moved on
        step(1'b0, RT, 5'd5, 5'd1, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, RT, 5'd5, 5'd1, IMM, 5'd0, 1'b0, 1'b0, 1'b0);
        // load-use on rs2 of a store; x0 destination; LUI does not read rs2
        step(1'b0, ST, 5'd1, 5'd7, LD, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b0, RT, 5'd0, 5'd0, LD, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, LUI, 5'd3, 5'd5, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, IMM, 5'd1, 5'd5, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        // redirects
        step(1'b0, RT, 5'd1, 5'd2, BR, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, RT, 5'd1, 5'd2, BR, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, RT, 5'd1, 5'd2, JALR, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, RT, 5'd1, 5'd2, JAL, 5'd1, 1'b0, 1'b0, 1'b0);
        // redirect beats a simultaneous load-use and an illegal muldiv
        step(1'b0, RT, 5'd4, 5'd2, JAL, 5'd4, 1'b1, 1'b0, 1'b1);
        // div held in EX while stalled; load-use present but ignored while waiting
        step(1'b0, RT, 5'd1, 5'd2, RT, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, RT, 5'd9, 5'd2, RT, 5'd9, 1'b1, 1'b0, 1'b1);
        step(1'b0, RT, 5'd1, 5'd2, BR, 5'd9, 1'b0, 1'b1, 1'b1);
        step(1'b0, RT, 5'd1, 5'd2, RT, 5'd9, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, IMM, 5'd1, 5'd2, IMM, 5'd3, 1'b0, 1'b0, 1'b0);
        // reset lands in the third stall cycle of the latency-8 op
        step(1'b0, RT, 5'd1, 5'd2, RT, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, RT, 5'd1, 5'd2, RT, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, RT, 5'd1, 5'd2, RT, 5'd9, 1'b0, 1'b0, 1'b1);
        step(1'b0, RT, 5'd5, 5'd2, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, IMM, 5'd1, 5'd2, IMM, 5'd3, 1'b0, 1'b0, 1'b0);

        // random traffic, small register range to provoke hazards
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0), pick_op(), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), pick_op(), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 6) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the RV32IMA five-stage core: the block that drives the pipeline `stall` and `flush` controls. It detects load-use hazards between ID and EX and control-flow redirects resolved in EX. With the M-extension wait feature compiled in, it also holds EX for a fixed-latency multiply/divide. It sits beside the datapath and drives the PC, IF/ID and ID/EX register enables and clears; the pipeline stall/flush formal checkers observe its `stall` and `flush` outputs.

## Interface
- `MULDIV_LATENCY`, default 4: total EX-stage cycles of an M-extension op. Legal range 2..32. Counter width is `$clog2(MULDIV_LATENCY)`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_opcode` in 7: opcode of the instruction in ID.
- `id_rs1` in 5, `id_rs2` in 5: source register indices of the instruction in ID.
- `ex_opcode` in 7: opcode of the instruction in EX.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load or AMO read.
- `ex_branch_taken` in 1: branch condition evaluated true in EX.
- `ex_muldiv` in 1: the instruction in EX is an M-extension op.
- `stall` out 1: freeze PC and IF/ID.
- `id_bubble` out 1: ID/EX loads a NOP.
- `ex_hold` out 1: freeze ID/EX; EX/MEM loads a NOP.
- `flush` out 1: clear IF/ID and ID/EX; PC takes the redirect target.
- `muldiv_busy` out 1: FSM is in MULDIV_WAIT.

## Operation
- **rs1 used:** true unless `id_opcode` is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- **rs2 used:** true for branch 1100011, store 0100011, R-type 0110011 and AMO 0101111.
- **load_use:** `ex_mem_read` && `ex_rd` != 0 && ((rs1 used && `ex_rd` == `id_rs1`) || (rs2 used && `ex_rd` == `id_rs2`)).
- **redirect:** (`ex_opcode` == 1100011 && `ex_branch_taken`) || `ex_opcode` == 1101111 || `ex_opcode` == 1100111.
- **Invariant:** `flush` is never asserted for any other EX opcode.
- **FSM states:** RUN and MULDIV_WAIT. The 5-bit-max down-counter `cnt` is valid in MULDIV_WAIT only.
- **RUN, priority redirect > muldiv > load_use:**
  - redirect: `flush`=1, other outputs 0, stay in RUN.
  - `ex_muldiv`: `stall`=1, `ex_hold`=1; `cnt` <= `MULDIV_LATENCY`-2; go to MULDIV_WAIT.
  - Exception: when `MULDIV_LATENCY`==2, no wait state is entered. Stall lasts this single cycle and the FSM stays in RUN.
  - load_use: `stall`=1, `id_bubble`=1 for one cycle.
- **MULDIV_WAIT:**
  - If `cnt` != 0: `stall`=1, `ex_hold`=1, `cnt` decrements.
  - If `cnt` == 0: all outputs 0; go to RUN.
  - `load_use` and redirect are ignored in this state.
- **Simultaneous events:** redirect and `ex_muldiv` both high is impossible in a legal EX slot. If it occurs anyway, flush wins and `cnt` is not loaded.
- **Reset:** while `reset` is high, all outputs are forced 0 combinationally. At the next edge, state <= RUN and `cnt` <= 0, including when reset lands in the middle of MULDIV_WAIT.

## Timing
- `stall`, `id_bubble`, `ex_hold` and `flush` are combinational from inputs and state, valid in the same cycle. There is no registered latency.
- `muldiv_busy` is registered and rises one cycle after the M op reaches EX.
- A load-use stall lasts exactly 1 cycle.
- A flush lasts exactly 1 cycle per redirecting instruction.
- An M op produces exactly `MULDIV_LATENCY`-1 consecutive `stall` cycles. It advances on the last cycle, in which `stall`=0.
- Output values out of reset: all outputs 0.

## Configuration
- **Macro:** `MULDIV_STALL_EN`.
- **Defined:** FSM, `cnt` and the muldiv behaviour exactly as above.
- **Undefined:**
  - `ex_muldiv` is ignored and the FSM is permanently RUN.
  - `ex_hold` and `muldiv_busy` are tied 0. This configuration is for a single-cycle multiplier.
  - `MULDIV_LATENCY` is unused.

## Test plan
- **Load-use:** EX lw with `ex_rd`=5; ID add with `id_rs1`=5 -> `stall`=1 and `id_bubble`=1 for 1 cycle; `flush`=0.
- **x0 and unused rs2:** `ex_rd`=0 with `ex_mem_read`=1 and `id_rs1`=0 -> no stall. ID LUI with `id_rs2` field=5 and `ex_rd`=5 -> no stall.
- **Redirect:**
  - EX beq with `ex_branch_taken`=1 -> `flush`=1 for 1 cycle.
  - EX beq with `ex_branch_taken`=0 -> `flush`=0.
  - EX JALR -> `flush`=1.
  - Randomized EX opcodes outside {1100011, 1101111, 1100111} -> `flush` never 1.
- **Muldiv, `MULDIV_LATENCY`=4, macro defined:** EX div -> `stall`=`ex_hold`=1 for 3 cycles, then 0; `muldiv_busy` high for cycles 2–4.
- **Reset mid-wait:** with `MULDIV_LATENCY`=8, assert `reset` in the 3rd stall cycle -> outputs 0 immediately; after reset, `muldiv_busy`=0 and state is RUN.
- **Macro undefined:** `ex_muldiv`=1 -> `stall`=0, `ex_hold`=0, `muldiv_busy`=0.
